// File: rtl/read_port_buf_if.sv
// Bundle of read-port signals between the buffer (slave) and its
// environment (master): DUT pop side, FPGA push side and sticky error flags.
//   read_active      master->slave  per-channel pop request
//   read_valid       slave->master  per-channel head available
//   read_data        slave->master  per-channel head payload
//   read_inst_active slave->master  per-channel ready to accept an FPGA word
//   read_port_valid  master->slave  per-channel FPGA word present
//   read_port_data   master->slave  per-channel {payload, sequence}
//   err_clr          master->slave  clear all sticky flags
//   sync_err/ovf_err slave->master  sticky sequence / overflow flags
interface read_port_buf_if #(
  parameter int unsigned NUM_CH = 2,
  parameter int unsigned DATA_W = 64,
  parameter int unsigned SYNC_W = 32
);
  logic [NUM_CH-1:0]                 read_active;
  logic [NUM_CH-1:0]                 read_valid;
  logic [NUM_CH*DATA_W-1:0]          read_data;
  logic [NUM_CH-1:0]                 read_inst_active;
  logic [NUM_CH-1:0]                 read_port_valid;
  logic [NUM_CH*(SYNC_W+DATA_W)-1:0] read_port_data;
  logic                              err_clr;
  logic [NUM_CH-1:0]                 sync_err;
  logic [NUM_CH-1:0]                 ovf_err;

  modport master (
    output read_active, read_port_valid, read_port_data, err_clr,
    input  read_valid, read_data, read_inst_active, sync_err, ovf_err
  );

  modport slave (
    input  read_active, read_port_valid, read_port_data, err_clr,
    output read_valid, read_data, read_inst_active, sync_err, ovf_err
  );
endinterface

// File: rtl/read_port_buf.sv
// Per-channel read buffer: FPGA words are pushed into a DEPTH-entry FIFO with
// the sequence field stripped and checked against an expected counter; the DUT
// pops the head payload.
//   clk  - clock, all state changes on rising edge
//   rst  - synchronous active-high reset
//   bus  - read_port_buf_if.slave (see interface for signal directions)
module read_port_buf #(
  parameter int unsigned NUM_CH = 2,
  parameter int unsigned DATA_W = 64,
  parameter int unsigned SYNC_W = 32,
  parameter int unsigned DEPTH  = 4
) (
  input  logic             clk,
  input  logic             rst,
  read_port_buf_if.slave   bus
);

  localparam int unsigned WORD_W = SYNC_W + DATA_W;
  localparam int unsigned PTR_W  = $clog2(DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;

  logic [DATA_W-1:0] r_mem     [NUM_CH][DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr  [NUM_CH];
  logic [PTR_W-1:0]  r_rd_ptr  [NUM_CH];
  logic [CNT_W-1:0]  r_cnt     [NUM_CH];
  logic [SYNC_W-1:0] r_exp_seq [NUM_CH];
  logic [NUM_CH-1:0] r_sync_err;
  logic [NUM_CH-1:0] r_ovf_err;

  logic [NUM_CH-1:0] w_full;
  logic [NUM_CH-1:0] w_empty;
  logic [NUM_CH-1:0] w_push;
  logic [NUM_CH-1:0] w_pop;
  logic [NUM_CH-1:0] w_drop;
  logic [NUM_CH-1:0] w_seq_bad;
  logic [SYNC_W-1:0] w_seq     [NUM_CH];
  logic [DATA_W-1:0] w_pay     [NUM_CH];
  logic [NUM_CH*DATA_W-1:0] w_read_data;

  // Per-channel status decode and push/pop qualification
  always_comb begin
    w_full    = '0;
    w_empty   = '0;
    w_push    = '0;
    w_pop     = '0;
    w_drop    = '0;
    w_seq_bad = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      w_seq[c]     = bus.read_port_data[c*WORD_W +: SYNC_W];
      w_pay[c]     = bus.read_port_data[c*WORD_W + SYNC_W +: DATA_W];
      w_full[c]    = (r_cnt[c] == CNT_W'(DEPTH));
      w_empty[c]   = (r_cnt[c] == '0);
      w_push[c]    = bus.read_port_valid[c] & ~w_full[c];
      w_drop[c]    = bus.read_port_valid[c] & w_full[c];
      w_pop[c]     = bus.read_active[c] & ~w_empty[c];
      w_seq_bad[c] = w_push[c] & (w_seq[c] != r_exp_seq[c]);
    end
  end

  // Head payload, forced to zero when the channel has nothing to show
  always_comb begin
    w_read_data = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (!rst && !w_empty[c]) begin
        w_read_data[c*DATA_W +: DATA_W] = r_mem[c][r_rd_ptr[c]];
      end
    end
  end

  // rst gates the status outputs directly since counts clear only on the edge
  assign bus.read_valid       = rst ? '0 : ~w_empty;
  assign bus.read_inst_active = rst ? '0 : ~w_full;
  assign bus.read_data        = w_read_data;
  assign bus.sync_err         = r_sync_err;
  assign bus.ovf_err          = r_ovf_err;

  // FIFO storage; contents need no reset since pointers/counts define validity
  always_ff @(posedge clk) begin
    for (int c = 0; c < NUM_CH; c++) begin
      if (!rst && w_push[c]) begin
        r_mem[c][r_wr_ptr[c]] <= w_pay[c];
      end
    end
  end

  // Pointers, counts, expected sequence and sticky flags
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < NUM_CH; c++) begin
        r_wr_ptr[c]  <= '0;
        r_rd_ptr[c]  <= '0;
        r_cnt[c]     <= '0;
        r_exp_seq[c] <= '0;
      end
      r_sync_err <= '0;
      r_ovf_err  <= '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (w_push[c]) begin
          r_wr_ptr[c]  <= r_wr_ptr[c] + PTR_W'(1);
          // Resynchronise to whatever arrived, even on a mismatch
          r_exp_seq[c] <= w_seq[c] + SYNC_W'(1);
        end
        if (w_pop[c]) begin
          r_rd_ptr[c] <= r_rd_ptr[c] + PTR_W'(1);
        end
        if (w_push[c] && !w_pop[c]) begin
          r_cnt[c] <= r_cnt[c] + CNT_W'(1);
        end else if (w_pop[c] && !w_push[c]) begin
          r_cnt[c] <= r_cnt[c] - CNT_W'(1);
        end
      end
      // New events take priority over a coincident clear
      r_sync_err <= w_seq_bad | (r_sync_err & ~{NUM_CH{bus.err_clr}});
      r_ovf_err  <= w_drop    | (r_ovf_err  & ~{NUM_CH{bus.err_clr}});
    end
  end

endmodule

// File: doc/read_port_buf.md
READ_PORT_BUF -- requirements
Module: read_port_buf

Interface
REQ-001 The block SHALL have parameter NUM_CH, default 2, meaning the number of independent read channels (range 1..8).
REQ-002 The block SHALL have parameter DATA_W, default 64, meaning the payload width per channel delivered to the DUT.
REQ-003 The block SHALL have parameter SYNC_W, default 32, meaning the width of the sync/sequence field in the low bits of each FPGA word.
REQ-004 The block SHALL have parameter DEPTH, default 4, meaning the entries per channel FIFO (power of 2, at least 2).
REQ-005 The block SHALL have one clock and a synchronous, active-high reset, with ports as follows:
- clk  in  1  clock; all state changes on its rising edge.
- rst  in  1  reset.
- read_active  in  NUM_CH  DUT pop request per channel.
- read_valid  out  NUM_CH  head entry available per channel.
- read_data  out  NUM_CH*DATA_W  head payload; channel c occupies bits [c*DATA_W +: DATA_W].
- read_inst_active  out  NUM_CH  ready to FPGA state machines; high when channel c can accept a word.
- read_port_valid  in  NUM_CH  FPGA word present per channel.
- read_port_data  in  NUM_CH*(SYNC_W+DATA_W)  FPGA word; per channel, the low SYNC_W bits are the sequence number and the upper DATA_W bits are the payload.
- err_clr  in  1  clears all sticky error flags.
- sync_err  out  NUM_CH  sticky sequence-mismatch flag.
- ovf_err  out  NUM_CH  sticky push-while-full flag.

Function
REQ-006 Each channel SHALL contain its own FIFO of DEPTH entries storing payload only, with the sync field stripped, plus a registered occupancy count of width clog2(DEPTH)+1.
REQ-007 The full and empty conditions SHALL be decoded from the count at the start of the cycle (full: count==DEPTH; empty: count==0).
REQ-008 read_inst_active[c] SHALL equal !full[c] and SHALL be held low while rst is high.
REQ-009 A push SHALL occur when read_port_valid[c] && !full[c]; the payload is read_port_data bits [SYNC_W +: DATA_W] of channel c.
REQ-010 When read_port_valid[c] && full[c], the word SHALL be discarded, ovf_err[c] set, and the expected sequence left unchanged; this applies even if a pop occurs in the same cycle.
REQ-011 read_valid[c] SHALL equal !empty[c].
REQ-012 read_data for channel c SHALL show the head payload when read_valid[c] is high and SHALL be zero otherwise.
REQ-013 A pop SHALL occur when read_active[c] && read_valid[c]; read_active while empty SHALL be ignored and SHALL raise no error.
REQ-014 Push-to-read_valid latency SHALL be 1 cycle; a word pushed into an empty FIFO is visible on the next cycle, and there is no same-cycle bypass.
REQ-015 On a simultaneous push and pop, the count SHALL be unchanged, both pointers SHALL advance, and data order SHALL be preserved.
REQ-016 Read and write pointers SHALL wrap modulo DEPTH.
REQ-017 Each channel SHALL keep an expected-sequence register exp_seq[c] of SYNC_W bits, reset to 0.
REQ-018 On each accepted push, if the sequence field != exp_seq[c], then sync_err[c] SHALL be set and the data SHALL still be stored.
REQ-019 On each accepted push, exp_seq[c] SHALL become (received sequence + 1) mod 2^SYNC_W, so the channel resynchronises to the received value; 0xFFFFFFFF is followed by 0.
REQ-020 err_clr SHALL clear sync_err and ovf_err on all channels; if an error event and err_clr occur in the same cycle, the flag SHALL be set (set wins).
REQ-021 Channels SHALL be fully independent; activity on one channel SHALL not affect the state or timing of another.
REQ-022 The block SHALL perform no combinational path from read_port_data to read_data.

Reset
REQ-023 While rst is high, the following SHALL hold on the next edge: all counts=0, pointers=0, exp_seq=0, sync_err=0, ovf_err=0.
REQ-024 While rst is high, the outputs SHALL be read_valid=0, read_data=0, read_inst_active=0.
REQ-025 Reset asserted mid-operation SHALL discard all buffered words; pushes and pops presented in the rst cycle SHALL be ignored.
REQ-026 read_inst_active SHALL rise in the first cycle after rst deasserts.

Verification
REQ-027 Single word: ch0 gets seq=0, payload 0xA5A5_0000_1234_5678 -> next cycle read_valid[0]=1 and read_data ch0 = that payload; read_active pops it; the following cycle read_valid[0]=0 and read_data=0.
REQ-028 Fill to full: DEPTH=4, push seq 0..3 with no pops -> read_inst_active[0]=0; a 5th push (seq 4) sets ovf_err[0]; popping yields seq 0..3 payloads in order.
REQ-029 Full with simultaneous push and pop: the push is dropped and ovf_err is set, while the pop succeeds -> count=3.
REQ-030 Sequence gap: push seq 0, 1, 5, 6 -> sync_err[0] sets on the seq-5 push only; seq 6 raises no new error; err_clr then clears it; err_clr coinciding with a new mismatch -> the flag remains 1.
REQ-031 Wrap: exp_seq forced via pushes to 0xFFFFFFFF, then push 0xFFFFFFFF followed by 0x00000000 -> no sync_err.
REQ-032 Reset mid-stream: 3 words buffered on ch1, assert rst for 1 cycle -> read_valid[1]=0, flags=0, and a next push with seq 0 produces no sync_err; ch0 is shown to run unaffected by ch1 traffic before the reset.
